// File: rtl/tile_addr_gen.sv
// ---------------------------------------------------------------------------
// tile_addr_gen
//   Address/control sequencer for a DxD output-stationary systolic array.
//   A job multiplies an MxK matrix A by a KxN matrix B. The output is walked
//   tile by tile (row tiles mt, column tiles nt). Each tile runs four phases:
//     CLEAR : one cycle of sa_rst to zero the array accumulators
//     FEED  : K+2D cycles streaming A/B buffer reads, with skewed lane valids
//     WRITE : D cycles writing one array row per cycle into the C buffer
//     NEXT  : one cycle advancing to the next tile, or on to DONE
//   A job with K, M or N equal to zero goes straight to DONE.
//
// Parameters
//   ARRAY_DIM  systolic array side D (2..16)
//   ADDR_BITS  width of the A/B/C buffer indices (wraps on overflow)
//   DIM_BITS   width of the K/M/N job dimensions
//
// Ports
//   axis_clk     clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     start request, honoured only while idle; K/M/N sampled with it
//   K, M, N      reduction depth, A rows, B columns
//   busy         high from the cycle after acceptance through the DONE cycle
//   done         one-cycle completion pulse
//   A_index      A buffer read address
//   B_index      B buffer read address
//   sa_rst       accumulator clear for the array
//   lane_valid   per-lane operand valid, skewed by lane number
//   C_wr_en      C buffer write strobe
//   C_index      C buffer write address
//   C_row        array row being written out
//   perf_cycles  busy-cycle counter
//
// Build option
//   TILE_ADDR_GEN_PERF_EN  when defined, perf_cycles counts busy cycles
//                          (saturating, cleared on job acceptance); when not
//                          defined, perf_cycles is tied to zero.
// ---------------------------------------------------------------------------
module tile_addr_gen #(
    parameter int ARRAY_DIM = 4,
    parameter int ADDR_BITS = 16,
    parameter int DIM_BITS  = 8
) (
    input  logic                         axis_clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [DIM_BITS-1:0]          K,
    input  logic [DIM_BITS-1:0]          M,
    input  logic [DIM_BITS-1:0]          N,
    output logic                         busy,
    output logic                         done,
    output logic [ADDR_BITS-1:0]         A_index,
    output logic [ADDR_BITS-1:0]         B_index,
    output logic                         sa_rst,
    output logic [ARRAY_DIM-1:0]         lane_valid,
    output logic                         C_wr_en,
    output logic [ADDR_BITS-1:0]         C_index,
    output logic [$clog2(ARRAY_DIM)-1:0] C_row,
    output logic [31:0]                  perf_cycles
);

    // Headroom so K+2D-1 and row/column offsets plus D never overflow.
    localparam int T_W   = DIM_BITS + 6;
    localparam int ROW_W = $clog2(ARRAY_DIM);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_WRITE, S_NEXT, S_DONE
    } state_t;

    state_t               r_state;
    logic [DIM_BITS-1:0]  r_k, r_m, r_n;
    logic [T_W-1:0]       r_t;
    logic [ROW_W-1:0]     r_r;
    logic [T_W-1:0]       r_mrow;     // mt*D: first A row of the current tile
    logic [T_W-1:0]       r_ncol;     // nt*D: first B column of the current tile
    logic [ADDR_BITS-1:0] r_a_base;   // mt*K
    logic [ADDR_BITS-1:0] r_b_base;   // nt*K
    logic [ADDR_BITS-1:0] r_c_base;   // (mt*NT+nt)*D

    logic [T_W-1:0]       w_t_nxt;
    logic [T_W-1:0]       w_feed_last;
    logic [ROW_W-1:0]     w_r_nxt;
    logic                 w_last_col;
    logic                 w_last_row;
    logic                 w_degenerate;

    // Lane i sees its first operand one read-latency cycle plus i skew cycles
    // after t=0, and stays valid for K cycles.
    function automatic logic [ARRAY_DIM-1:0] lane_mask(input logic [T_W-1:0]      t,
                                                       input logic [DIM_BITS-1:0] k);
        logic [ARRAY_DIM-1:0] m;
        m = '0;
        for (int i = 0; i < ARRAY_DIM; i++) begin
            m[i] = (t >= T_W'(i + 1)) && (t < T_W'(k) + T_W'(i + 1));
        end
        return m;
    endfunction

    assign w_t_nxt      = r_t + 1'b1;
    assign w_feed_last  = T_W'(r_k) + T_W'(2 * ARRAY_DIM - 1);
    assign w_r_nxt      = r_r + 1'b1;
    // Tile walk ends when the next D-wide step would start at or past M / N;
    // equivalent to comparing against ceil(M/D) and ceil(N/D) without a divider.
    assign w_last_col   = (r_ncol + T_W'(ARRAY_DIM)) >= T_W'(r_n);
    assign w_last_row   = (r_mrow + T_W'(ARRAY_DIM)) >= T_W'(r_m);
    assign w_degenerate = (K == '0) || (M == '0) || (N == '0);

    // Outputs are registered: each transition loads the values for the state
    // being entered, so they line up with r_state in the same cycle.
    always_ff @(posedge axis_clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_m        <= '0;
            r_n        <= '0;
            r_t        <= '0;
            r_r        <= '0;
            r_mrow     <= '0;
            r_ncol     <= '0;
            r_a_base   <= '0;
            r_b_base   <= '0;
            r_c_base   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sa_rst     <= 1'b0;
            lane_valid <= '0;
            C_wr_en    <= 1'b0;
            A_index    <= '0;
            B_index    <= '0;
            C_index    <= '0;
            C_row      <= '0;
        end else begin
            sa_rst     <= 1'b0;
            lane_valid <= '0;
            C_wr_en    <= 1'b0;
            done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_k      <= K;
                        r_m      <= M;
                        r_n      <= N;
                        r_mrow   <= '0;
                        r_ncol   <= '0;
                        r_a_base <= '0;
                        r_b_base <= '0;
                        r_c_base <= '0;
                        busy     <= 1'b1;
                        if (w_degenerate) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_CLEAR;
                            sa_rst  <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    // K is nonzero here, so t=0 always issues a read.
                    r_state <= S_FEED;
                    r_t     <= '0;
                    A_index <= r_a_base;
                    B_index <= r_b_base;
                end
                S_FEED: begin
                    if (r_t == w_feed_last) begin
                        r_state <= S_WRITE;
                        r_r     <= '0;
                        C_wr_en <= 1'b1;
                        C_row   <= '0;
                        C_index <= r_c_base;
                    end else begin
                        r_t        <= w_t_nxt;
                        lane_valid <= lane_mask(w_t_nxt, r_k);
                        // Past the last K element the addresses hold.
                        if (w_t_nxt < T_W'(r_k)) begin
                            A_index <= r_a_base + ADDR_BITS'(w_t_nxt);
                            B_index <= r_b_base + ADDR_BITS'(w_t_nxt);
                        end
                    end
                end
                S_WRITE: begin
                    if (r_r == ROW_W'(ARRAY_DIM - 1)) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_r     <= w_r_nxt;
                        C_wr_en <= 1'b1;
                        C_row   <= w_r_nxt;
                        C_index <= r_c_base + ADDR_BITS'(w_r_nxt);
                    end
                end
                S_NEXT: begin
                    r_c_base <= r_c_base + ADDR_BITS'(ARRAY_DIM);
                    if (w_last_col && w_last_row) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_state <= S_CLEAR;
                        sa_rst  <= 1'b1;
                        if (w_last_col) begin
                            r_ncol   <= '0;
                            r_b_base <= '0;
                            r_mrow   <= r_mrow + T_W'(ARRAY_DIM);
                            r_a_base <= r_a_base + ADDR_BITS'(r_k);
                        end else begin
                            r_ncol   <= r_ncol + T_W'(ARRAY_DIM);
                            r_b_base <= r_b_base + ADDR_BITS'(r_k);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef TILE_ADDR_GEN_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge axis_clk) begin
        if (!rst_n) begin
            r_perf <= '0;
        end else if ((r_state == S_IDLE) && in_valid) begin
            r_perf <= '0;
        end else if (busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 1'b1;
        end
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_tile_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_tile_addr_gen
//   Directed bench for tile_addr_gen with D=4, ADDR_BITS=16, DIM_BITS=8.
//   Each job is followed cycle by cycle against a timeline derived from the
//   tile schedule (CLEAR, FEED K+2D, WRITE D, NEXT per tile, then DONE), and
//   summary figures (busy length, write count, addresses) are compared
//   against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_tile_addr_gen;

    localparam int D  = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic                   axis_clk;
    logic                   rst_n;
    logic                   in_valid;
    logic [DW-1:0]          K, M, N;
    logic                   busy, done, sa_rst, C_wr_en;
    logic [AW-1:0]          A_index, B_index, C_index;
    logic [D-1:0]           lane_valid;
    logic [$clog2(D)-1:0]   C_row;
    logic [31:0]            perf_cycles;

    int n_checks = 0;
    int n_errors = 0;

    tile_addr_gen #(.ARRAY_DIM(D), .ADDR_BITS(AW), .DIM_BITS(DW)) dut (
        .axis_clk    (axis_clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .K           (K),
        .M           (M),
        .N           (N),
        .busy        (busy),
        .done        (done),
        .A_index     (A_index),
        .B_index     (B_index),
        .sa_rst      (sa_rst),
        .lane_valid  (lane_valid),
        .C_wr_en     (C_wr_en),
        .C_index     (C_index),
        .C_row       (C_row),
        .perf_cycles (perf_cycles)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"},  32'(busy),        0);
        check_val({tag, "_done"},  32'(done),        0);
        check_val({tag, "_sarst"}, 32'(sa_rst),      0);
        check_val({tag, "_wr"},    32'(C_wr_en),     0);
        check_val({tag, "_lv"},    32'(lane_valid),  0);
        check_val({tag, "_A"},     32'(A_index),     0);
        check_val({tag, "_B"},     32'(B_index),     0);
        check_val({tag, "_C"},     32'(C_index),     0);
        check_val({tag, "_row"},   32'(C_row),       0);
        check_val({tag, "_perf"},  perf_cycles,      0);
    endtask

    // Expected outputs c cycles after the acceptance edge (c=0 is the first
    // cycle with busy high).
    task automatic check_cycle(input int k, input int m, input int n, input int c);
        int mt_cnt, nt_cnt, len, tiles, total, tile, p, mt, nt, t, tt, r;
        logic e_sa, e_wr;
        logic [D-1:0] e_lv;
        e_sa = 1'b0;
        e_wr = 1'b0;
        e_lv = '0;
        mt_cnt = (m + D - 1) / D;
        nt_cnt = (n + D - 1) / D;
        len    = k + 3 * D + 2;
        tiles  = (k == 0 || m == 0 || n == 0) ? 0 : mt_cnt * nt_cnt;
        total  = tiles * len + 1;
        if (c < tiles * len) begin
            tile = c / len;
            p    = c % len;
            mt   = tile / nt_cnt;
            nt   = tile % nt_cnt;
            if (p == 0) begin
                e_sa = 1'b1;
            end else if (p <= k + 2 * D) begin
                t  = p - 1;
                for (int i = 0; i < D; i++) e_lv[i] = (t - 1 - i >= 0) && (t - 1 - i < k);
                tt = (t < k) ? t : k - 1;
                check_val("feed_A", 32'(A_index), 32'(AW'(mt * k + tt)));
                check_val("feed_B", 32'(B_index), 32'(AW'(nt * k + tt)));
            end else if (p <= k + 3 * D) begin
                r    = p - (k + 2 * D + 1);
                e_wr = 1'b1;
                check_val("wr_row", 32'(C_row),   32'(r));
                check_val("wr_idx", 32'(C_index), 32'(AW'(tile * D + r)));
            end
        end
        check_val("busy",  32'(busy),       32'(c < total));
        check_val("done",  32'(done),       32'(c == total - 1));
        check_val("sarst", 32'(sa_rst),     32'(e_sa));
        check_val("wr_en", 32'(C_wr_en),    32'(e_wr));
        check_val("lanes", 32'(lane_valid), 32'(e_lv));
    endtask

    // Launch a job, follow it to idle and return summary figures.
    task automatic run_job(input int k, input int m, input int n, input bit poke,
                           output int busy_cnt, output int done_cnt, output int wr_cnt,
                           output int c_first, output int c_last, output int b_t1);
        int total, len, mt_cnt, nt_cnt;
        bit deg;
        busy_cnt = 0;
        done_cnt = 0;
        wr_cnt   = 0;
        c_first  = -1;
        c_last   = -1;
        b_t1     = -1;
        deg      = (k == 0 || m == 0 || n == 0);
        mt_cnt   = (m + D - 1) / D;
        nt_cnt   = (n + D - 1) / D;
        len      = k + 3 * D + 2;
        total    = deg ? 1 : mt_cnt * nt_cnt * len + 1;
        K = DW'(k);
        M = DW'(m);
        N = DW'(n);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        // Dimensions must have been latched at acceptance.
        K = 8'd9;
        M = 8'd9;
        N = 8'd9;
        for (int c = 0; c < total + 2; c++) begin
            check_cycle(k, m, n, c);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (C_wr_en) begin
                if (c_first < 0) c_first = int'(C_index);
                c_last = int'(C_index);
                wr_cnt++;
            end
            if (c == len + 1) b_t1 = int'(B_index);
            in_valid = (poke && c == 5) ? 1'b1 : 1'b0;
            step();
        end
        in_valid = 1'b0;
`ifdef TILE_ADDR_GEN_PERF_EN
        check_val("perf_end", perf_cycles, 32'(total));
`else
        check_val("perf_end", perf_cycles, 32'd0);
`endif
    endtask

    initial begin
        int bc, dc, wc, cf, cl, bt;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        K = '0;
        M = '0;
        N = '0;
        step();
        step();
        check_all_zero("rst");
        rst_n = 1'b1;
        step();
        check_all_zero("idle");

        // 4x4x4 single tile
        run_job(4, 4, 4, 1'b0, bc, dc, wc, cf, cl, bt);
        check_val("j1_busy", 32'(bc), 19);
        check_val("j1_done", 32'(dc), 1);
        check_val("j1_wrs",  32'(wc), 4);
        check_val("j1_c0",   32'(cf), 0);
        check_val("j1_c3",   32'(cl), 3);

        // K=0: no reads, no writes; addresses keep last job's final value
        run_job(0, 4, 4, 1'b0, bc, dc, wc, cf, cl, bt);
        check_val("deg_busy", 32'(bc), 1);
        check_val("deg_done", 32'(dc), 1);
        check_val("deg_wrs",  32'(wc), 0);
        check_val("deg_A",    32'(A_index), 3);
        check_val("deg_B",    32'(B_index), 3);

        // 2x2 tiles, K=2
        run_job(2, 8, 5, 1'b0, bc, dc, wc, cf, cl, bt);
        check_val("j2_busy", 32'(bc), 65);
        check_val("j2_done", 32'(dc), 1);
        check_val("j2_wrs",  32'(wc), 16);
        check_val("j2_c0",   32'(cf), 0);
        check_val("j2_c15",  32'(cl), 15);
        check_val("j2_b_nt1", 32'(bt), 2);

        // in_valid pulsed mid-FEED is ignored
        run_job(4, 4, 4, 1'b1, bc, dc, wc, cf, cl, bt);
        check_val("poke_busy", 32'(bc), 19);
        check_val("poke_done", 32'(dc), 1);
        check_val("poke_wrs",  32'(wc), 4);

        // Reset during WRITE r=2 (c = 1 + K+2D + 2 = 15)
        K = 8'd4;
        M = 8'd4;
        N = 8'd4;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c <= 15; c++) begin
            check_cycle(4, 4, 4, c);
            if (c < 15) step();
        end
        check_val("mid_row", 32'(C_row), 2);
        rst_n = 1'b0;
        step();
        check_all_zero("midrst");
        rst_n = 1'b1;
        step();
        check_all_zero("post");
        run_job(4, 4, 4, 1'b0, bc, dc, wc, cf, cl, bt);
        check_val("re_busy", 32'(bc), 19);
        check_val("re_c0",   32'(cf), 0);
        check_val("re_wrs",  32'(wc), 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "timeout");
    end

endmodule
